tx_module: RTL and testbench

UART transmitter: serialises one 8-bit byte per request into an asynchronous frame (start bit, 8 data bits LSB first, optional parity, one stop bit) on a single output pin. It is the transmit counterpart of the receive path and shares its bit timing, so a looped-back `TX_Pin_Out` → `RX_Pin_In` frame round-trips. It sits between the user logic and the board's RS232 TX pin.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/tx_bps_module.sv | 42 ++++
 rtl/tx_module.sv | 138 +++++++++++++
 tb/tb_tx_module.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: transmit FSM state encoding, parity
//               mode encodings, default bit divider and frame constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Parity mode encodings for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz / 115200 baud
    localparam int DEF_BPS_DIV = 434;

    // Frame layout
    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/tx_bps_module.sv
`default_nettype none
// ============================================================================
// Module      : tx_bps_module
// Description : Bit-period counter for the UART transmitter. Counts clock
//               cycles while enabled and issues a one-cycle strobe in the
//               last cycle of every bit period.
// Ports       : CLK       - clock, rising edge
//               RST       - synchronous active-high reset
//               Count_Sig - enable; counter is held at 0 while low
//               BPS_CLK   - bit-end strobe (count == BPS_DIV-1)
// Revision    : 1.0 - initial release
// ============================================================================
module tx_bps_module #(
    parameter int BPS_DIV = 434
) (
    input  logic CLK,
    input  logic RST,
    input  logic Count_Sig,
    output logic BPS_CLK
);

    localparam int         CW     = (BPS_DIV > 2) ? $clog2(BPS_DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(BPS_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (!Count_Sig) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign BPS_CLK = Count_Sig && (r_cnt == c_last);

endmodule : tx_bps_module
`default_nettype wire

// File: rtl/tx_module.sv
`default_nettype none
// ============================================================================
// Module      : tx_module
// Description : UART transmitter. Serialises one byte per request into a
//               start bit, 8 data bits (LSB first), optional parity bit and
//               one stop bit.
// Ports       : CLK         - clock, rising edge
//               RST         - synchronous active-high reset
//               TX_En_Sig   - send request, sampled only in IDLE
//               TX_Data     - byte to send, captured in the accept cycle
//               TX_Pin_Out  - serial line, idle high, registered
//               TX_Busy_Sig - high from the cycle after accept until the
//                             cycle after Done
//               TX_Done_Sig - one-cycle pulse in the last stop-bit cycle
// Revision    : 1.0 - initial release
// ============================================================================
module tx_module
    import uart_pkg::*;
#(
    parameter int BPS_DIV = DEF_BPS_DIV,
    parameter int PARITY  = PAR_NONE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_En_Sig,
    input  logic [7:0] TX_Data,
    output logic       TX_Pin_Out,
    output logic       TX_Busy_Sig,
    output logic       TX_Done_Sig
);

    localparam logic       c_has_parity = (PARITY != PAR_NONE);
    localparam logic [2:0] c_last_bit   = 3'(DATA_BITS - 1);

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_parity;
    logic       r_pin;
    logic       r_busy;

    logic       w_count_en;
    logic       w_bps_clk;

    // The bit timer runs in every state except IDLE, so it is always at 0
    // on entry to START.
    assign w_count_en = (r_state != ST_IDLE);

    tx_bps_module #(
        .BPS_DIV (BPS_DIV)
    ) u_bps (
        .CLK       (CLK),
        .RST       (RST),
        .Count_Sig (w_count_en),
        .BPS_CLK   (w_bps_clk)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_pin     <= STOP_BIT;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pin <= STOP_BIT;
                    if (TX_En_Sig) begin
                        r_shift   <= TX_Data;
                        r_bit_idx <= '0;
                        r_parity  <= (PARITY == PAR_ODD) ? ~^TX_Data : ^TX_Data;
                        r_busy    <= 1'b1;
                        // The pin register leads the state, so the start
                        // bit appears in the first START cycle.
                        r_pin     <= START_BIT;
                        r_state   <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_bps_clk) begin
                        r_pin   <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_bps_clk) begin
                        if (r_bit_idx == c_last_bit) begin
                            if (c_has_parity) begin
                                r_pin   <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_pin   <= STOP_BIT;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_pin     <= r_shift[1];
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_bps_clk) begin
                        r_pin   <= STOP_BIT;
                        r_state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_bps_clk) begin
                        r_busy  <= 1'b0;
                        r_pin   <= STOP_BIT;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_pin   <= STOP_BIT;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_Pin_Out  = r_pin;
    assign TX_Busy_Sig = r_busy;
    // Decoded from registered state and the registered bit counter only,
    // so it is a clean single-cycle pulse in the last stop-bit cycle.
    assign TX_Done_Sig = (r_state == ST_STOP) && w_bps_clk;

endmodule : tx_module
`default_nettype wire

// File: tb/tb_tx_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_module
// Description : Self-checking bench for tx_module. Three instances (no, odd
//               and even parity) share stimulus; a frame-level reference
//               model predicts line, busy and done every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_module;

    localparam int BPS = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic [7:0] data = 8'h00;
    logic [2:0] pin;
    logic [2:0] busy;
    logic [2:0] done;

    tx_module #(.BPS_DIV(BPS), .PARITY(0)) u_p0 (
        .CLK(clk), .RST(rst), .TX_En_Sig(en), .TX_Data(data),
        .TX_Pin_Out(pin[0]), .TX_Busy_Sig(busy[0]), .TX_Done_Sig(done[0]));
    tx_module #(.BPS_DIV(BPS), .PARITY(1)) u_p1 (
        .CLK(clk), .RST(rst), .TX_En_Sig(en), .TX_Data(data),
        .TX_Pin_Out(pin[1]), .TX_Busy_Sig(busy[1]), .TX_Done_Sig(done[1]));
    tx_module #(.BPS_DIV(BPS), .PARITY(2)) u_p2 (
        .CLK(clk), .RST(rst), .TX_En_Sig(en), .TX_Data(data),
        .TX_Pin_Out(pin[2]), .TX_Busy_Sig(busy[2]), .TX_Done_Sig(done[2]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, whether a frame is in flight, how many
    // cycles into it we are (1 = first start-bit cycle), and the frame bits.
    bit          m_act[3];
    int          m_k[3];
    int          m_n[3];
    logic [10:0] m_frame[3];
    int          m_done_cnt[3];
    int          d_done_cnt[3];
    int          cyc = 0;

    function automatic logic [10:0] make_frame(input int mode, input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (mode == 1) f[9] = ~(^d);   // odd: total ones odd
        if (mode == 2) f[9] = ^d;      // even: total ones even
        return f;
    endfunction

    function automatic bit all_idle();
        return !m_act[0] && !m_act[1] && !m_act[2];
    endfunction

    task automatic step();
        @(posedge clk);
        for (int p = 0; p < 3; p++) begin
            if (rst) begin
                m_act[p] = 1'b0;
            end else if (m_act[p]) begin
                if (m_k[p] == m_n[p] * BPS) m_act[p] = 1'b0;
                else m_k[p]++;
            end else if (en) begin
                m_act[p]   = 1'b1;
                m_k[p]     = 1;
                m_n[p]     = (p != 0) ? 11 : 10;
                m_frame[p] = make_frame(p, data);
            end
        end
        cyc++;
        #1;
        for (int p = 0; p < 3; p++) begin
            logic e_line, e_busy, e_done;
            e_line = m_act[p] ? m_frame[p][(m_k[p] - 1) / BPS] : 1'b1;
            e_busy = m_act[p];
            e_done = m_act[p] && (m_k[p] == m_n[p] * BPS);
            check($sformatf("line%0d@%0d", p, cyc), 32'(pin[p]), 32'(e_line));
            check($sformatf("busy%0d@%0d", p, cyc), 32'(busy[p]), 32'(e_busy));
            check($sformatf("done%0d@%0d", p, cyc), 32'(done[p]), 32'(e_done));
            if (done[p] === 1'b1) d_done_cnt[p]++;
            if (e_done) m_done_cnt[p]++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(all_idle()), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        data = b;
        en   = 1'b1;
        step();
        en   = 1'b0;
        data = 8'($urandom);   // must not affect the frame in flight
    endtask

    initial begin
        for (int p = 0; p < 3; p++) begin
            m_act[p] = 0; m_k[p] = 0; m_n[p] = 10; m_frame[p] = '1;
            m_done_cnt[p] = 0; d_done_cnt[p] = 0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Basic frame and parity frames
        send(8'hA5);
        wait_idle(200);
        step();
        send(8'h07);
        wait_idle(200);
        step();

        // Request while busy is ignored; line stays high afterwards
        send(8'h55);
        repeat (8) step();
        data = 8'h3C;
        en   = 1'b1;
        step();
        en   = 1'b0;
        wait_idle(200);
        repeat (20) step();

        // Back-to-back with request held high
        data = 8'h00;
        en   = 1'b1;
        step();
        data = 8'hFF;
        repeat (46) step();
        en = 1'b0;
        wait_idle(200);
        step();

        // Reset mid-frame, then a fresh frame
        send(8'hC3);
        repeat (13) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        send(8'h5A);
        wait_idle(200);

        // Request coinciding with reset is dropped
        rst  = 1'b1;
        en   = 1'b1;
        data = 8'h99;
        step();
        rst = 1'b0;
        en  = 1'b0;
        repeat (5) step();

        // 256 sequential bytes with random gaps and spurious requests
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 3)) step();
            send(8'(i));
            begin
                int n;
                n = 0;
                while (!all_idle() && n < 2000) begin
                    en   = ($urandom_range(0, 7) == 0);
                    data = 8'($urandom);
                    step();
                    n++;
                end
                en = 1'b0;
                wait_idle(200);
            end
        end
        repeat (5) step();

        for (int p = 0; p < 3; p++)
            check($sformatf("done_count%0d", p), 32'(d_done_cnt[p]), 32'(m_done_cnt[p]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tx_module
`default_nettype wire
